mul_datapath: RTL and testbench

- Register/ALU datapath for the 8-bit accumulator processor. It sits directly downstream of the multiply control sequencer and executes that sequencer's per-cycle control strobes.
- Holds PC, SP, MA, MD, AC, the 16-bit product accumulator AAC, and the flags. It drives the external memory interface.
- It returns status comparisons (AC zero, AC<MD, MD<2, and others) that the sequencer branches on.

---
 rtl/mul_pkg.sv | 61 ++++++
 rtl/mul_alu.sv | 57 +++++
 rtl/mul_datapath.sv | 221 ++++++++++++++++++++++
 tb/tb_mul_datapath.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared constants for the accumulator datapath: control-strobe
//                bit positions, ALU operation encoding, flag-byte layout and
//                the default stack-pointer reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // Control strobe bit positions within the ctrl bus
    localparam int CTRL_W      = 23;
    localparam int CTRL_ENPCA  = 0;
    localparam int CTRL_ENSPA  = 1;
    localparam int CTRL_ENMAA  = 2;
    localparam int CTRL_ENDES  = 3;
    localparam int CTRL_ENFLD  = 4;
    localparam int CTRL_MR_N   = 5;
    localparam int CTRL_MW_N   = 6;
    localparam int CTRL_LMAH   = 7;
    localparam int CTRL_LMAL   = 8;
    localparam int CTRL_LMD    = 9;
    localparam int CTRL_LAC    = 10;
    localparam int CTRL_LAAC   = 11;
    localparam int CTRL_LCARRY = 12;
    localparam int CTRL_LZERO  = 13;
    localparam int CTRL_LINT   = 14;
    localparam int CTRL_LINTE  = 15;
    localparam int CTRL_LRESET = 16;
    localparam int CTRL_INCPC  = 17;
    localparam int CTRL_INCSP  = 18;
    localparam int CTRL_DECSP  = 19;
    localparam int CTRL_OP1    = 20;
    localparam int CTRL_OP2    = 21;
    localparam int CTRL_SD0    = 22;

    // ALU operation encoding
    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2,
        ALU_SHR  = 2'd3
    } alu_op_e;

    // Flag byte layout: {5'b0, inte, carry, zero}
    localparam int FLAG_ZERO_BIT  = 0;
    localparam int FLAG_CARRY_BIT = 1;
    localparam int FLAG_INTE_BIT  = 2;

    localparam logic [15:0] SP_INIT_DEFAULT = 16'hFFFF;

    // SD0 has highest priority, then OP1+OP2 (subtract), then OP2 (add)
    function automatic alu_op_e alu_decode(input logic sd0, input logic op1, input logic op2);
        if (sd0)             return ALU_SHR;
        else if (op1 && op2) return ALU_SUB;
        else if (op2)        return ALU_ADD;
        else                 return ALU_PASS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_alu.sv
`default_nettype none
// ============================================================================
//  Module      : mul_alu
//  Description : Combinational ALU for the accumulator datapath: pass, add,
//                subtract-with-borrow and logical shift right, plus carry and
//                zero generation.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_alu
    import mul_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] ac_i,
    input  logic [DW-1:0] md_i,
    input  alu_op_e       op_i,
    input  logic          lac_i,
    output logic [DW-1:0] result_o,
    output logic          carry_o,
    output logic          zero_o
);

    logic [DW:0] w_sum;
    logic [DW:0] w_diff;

    assign w_sum  = {1'b0, ac_i} + {1'b0, md_i};
    // Top bit of the widened difference is the borrow (set when AC < MD)
    assign w_diff = {1'b0, ac_i} - {1'b0, md_i};

    // Operation select; pass forwards MD when the result is headed into AC
    always_comb begin
        result_o = ac_i;
        carry_o  = 1'b0;
        case (op_i)
            ALU_SHR: begin
                result_o = {1'b0, ac_i[DW-1:1]};
                carry_o  = ac_i[0];
            end
            ALU_SUB: begin
                result_o = w_diff[DW-1:0];
                carry_o  = w_diff[DW];
            end
            ALU_ADD: begin
                result_o = w_sum[DW-1:0];
                carry_o  = w_sum[DW];
            end
            default: begin
                result_o = lac_i ? md_i : ac_i;
                carry_o  = 1'b0;
            end
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule
`default_nettype wire

// File: rtl/mul_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : mul_datapath
//  Description : Register/ALU datapath of the 8-bit accumulator processor.
//                Executes per-cycle control strobes from the multiply
//                sequencer, drives the memory interface and returns status
//                comparisons for sequencer branching. AW must equal 2*DW.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_datapath
    import mul_pkg::*;
#(
    parameter int              DW      = 8,
    parameter int              AW      = 16,
    parameter logic [AW-1:0]   SP_INIT = SP_INIT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              irq,
    input  logic [DW-1:0]     mem_rdata,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DW-1:0]     ac,
    output logic [DW-1:0]     md,
    output logic [2*DW-1:0]   aac,
    output logic              flag_carry,
    output logic              flag_zero,
    output logic              inte,
    output logic              int_pend,
    output logic              ac_zero,
    output logic              md_zero,
    output logic              ac_lt_md,
    output logic              md_lt2,
    output logic              bus_err
);

    // Architectural state
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   sp_q, sp_d;
    logic [AW-1:0]   ma_q, ma_d;
    logic [DW-1:0]   md_q, md_d;
    logic [DW-1:0]   ac_q, ac_d;
    logic [2*DW-1:0] aac_q, aac_d;
    logic            carry_q, carry_d;
    logic            zero_q, zero_d;
    logic            inte_q, inte_d;
    logic            int_pend_q, int_pend_d;

    // Strobe decode
    logic w_enpca, w_enspa, w_enmaa, w_endes, w_enfld, w_mr_n, w_mw_n;
    logic w_lmah, w_lmal, w_lmd, w_lac, w_laac, w_lcarry, w_lzero;
    logic w_lint, w_linte, w_lreset, w_incpc, w_incsp, w_decsp;
    logic w_op1, w_op2, w_sd0;

    assign w_enpca  = ctrl[CTRL_ENPCA];
    assign w_enspa  = ctrl[CTRL_ENSPA];
    assign w_enmaa  = ctrl[CTRL_ENMAA];
    assign w_endes  = ctrl[CTRL_ENDES];
    assign w_enfld  = ctrl[CTRL_ENFLD];
    assign w_mr_n   = ctrl[CTRL_MR_N];
    assign w_mw_n   = ctrl[CTRL_MW_N];
    assign w_lmah   = ctrl[CTRL_LMAH];
    assign w_lmal   = ctrl[CTRL_LMAL];
    assign w_lmd    = ctrl[CTRL_LMD];
    assign w_lac    = ctrl[CTRL_LAC];
    assign w_laac   = ctrl[CTRL_LAAC];
    assign w_lcarry = ctrl[CTRL_LCARRY];
    assign w_lzero  = ctrl[CTRL_LZERO];
    assign w_lint   = ctrl[CTRL_LINT];
    assign w_linte  = ctrl[CTRL_LINTE];
    assign w_lreset = ctrl[CTRL_LRESET];
    assign w_incpc  = ctrl[CTRL_INCPC];
    assign w_incsp  = ctrl[CTRL_INCSP];
    assign w_decsp  = ctrl[CTRL_DECSP];
    assign w_op1    = ctrl[CTRL_OP1];
    assign w_op2    = ctrl[CTRL_OP2];
    assign w_sd0    = ctrl[CTRL_SD0];

    // ALU
    alu_op_e       w_alu_op;
    logic [DW-1:0] w_alu_out;
    logic          w_alu_carry;
    logic          w_alu_zero;

    assign w_alu_op = alu_decode(w_sd0, w_op1, w_op2);

    mul_alu #(
        .DW       (DW)
    ) u_alu (
        .ac_i     (ac_q),
        .md_i     (md_q),
        .op_i     (w_alu_op),
        .lac_i    (w_lac),
        .result_o (w_alu_out),
        .carry_o  (w_alu_carry),
        .zero_o   (w_alu_zero)
    );

    // Flag byte as seen on the data bus
    logic [DW-1:0] w_flag_byte;
    logic [DW-1:0] w_dbus;

    // Assemble the flag byte from the live flag registers
    always_comb begin
        w_flag_byte                 = '0;
        w_flag_byte[FLAG_ZERO_BIT]  = zero_q;
        w_flag_byte[FLAG_CARRY_BIT] = carry_q;
        w_flag_byte[FLAG_INTE_BIT]  = inte_q;
    end

    // Address mux: PC, then SP, then MA; only one should be enabled
    always_comb begin
        if (w_enpca)      mem_addr = pc_q;
        else if (w_enspa) mem_addr = sp_q;
        else if (w_enmaa) mem_addr = ma_q;
        else              mem_addr = '0;
    end

    // Data bus source: memory read wins, then flags, then ALU
    always_comb begin
        if (!w_mr_n)      w_dbus = mem_rdata;
        else if (w_enfld) w_dbus = w_flag_byte;
        else if (w_endes) w_dbus = w_alu_out;
        else              w_dbus = '0;
    end

    // Conflicts: multiple address sources, read+write, or a write with no driver
    assign bus_err = (w_enpca & w_enspa) | (w_enpca & w_enmaa) | (w_enspa & w_enmaa)
                   | (~w_mr_n & ~w_mw_n)
                   | (~w_mw_n & ~w_enfld & ~w_endes);

    assign mem_wdata = w_dbus;
    assign mem_re    = ~w_mr_n;
    assign mem_we    = ~w_mw_n & ~bus_err;

    // Next-state for all registers; loads proceed even during a bus conflict
    always_comb begin
        pc_d       = pc_q;
        sp_d       = sp_q;
        ma_d       = ma_q;
        md_d       = md_q;
        ac_d       = ac_q;
        aac_d      = aac_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        inte_d     = inte_q;
        int_pend_d = int_pend_q;

        if (w_incpc) pc_d = pc_q + AW'(1);

        case ({w_incsp, w_decsp})
            2'b10:   sp_d = sp_q + AW'(1);
            2'b01:   sp_d = sp_q - AW'(1);
            default: sp_d = sp_q;
        endcase

        if (w_lmah) ma_d[AW-1:DW] = w_dbus;
        if (w_lmal) ma_d[DW-1:0]  = w_dbus;
        if (w_lmd)  md_d          = w_dbus;
        if (w_lac)  ac_d          = w_dbus;

        // ALU flag update, then explicit restore takes precedence
        if (w_lac && w_endes) begin
            carry_d = w_alu_carry;
            zero_d  = w_alu_zero;
        end
        if (w_lcarry) carry_d = w_dbus[FLAG_CARRY_BIT];
        if (w_lzero)  zero_d  = w_dbus[FLAG_ZERO_BIT];
        if (w_linte)  inte_d  = w_dbus[FLAG_INTE_BIT];
        if (w_lint)   int_pend_d = irq;

        if (w_lreset)    aac_d = '0;
        else if (w_laac) aac_d = aac_q + {{(2*DW-DW){1'b0}}, w_dbus};
    end

    // State registers with synchronous reset dominating all strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= '0;
            sp_q       <= SP_INIT;
            ma_q       <= '0;
            md_q       <= '0;
            ac_q       <= '0;
            aac_q      <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            inte_q     <= 1'b0;
            int_pend_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            ma_q       <= ma_d;
            md_q       <= md_d;
            ac_q       <= ac_d;
            aac_q      <= aac_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            inte_q     <= inte_d;
            int_pend_q <= int_pend_d;
        end
    end

    assign ac         = ac_q;
    assign md         = md_q;
    assign aac        = aac_q;
    assign flag_carry = carry_q;
    assign flag_zero  = zero_q;
    assign inte       = inte_q;
    assign int_pend   = int_pend_q;

    // Status comparisons for sequencer branching
    assign ac_zero  = (ac_q == '0);
    assign md_zero  = (md_q == '0);
    assign ac_lt_md = (ac_q < md_q);
    assign md_lt2   = (md_q < DW'(2));

endmodule
`default_nettype wire

// File: tb/tb_mul_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_datapath
//  Description : Directed self-checking bench for mul_datapath. Control bit
//                positions are written out independently of the design package.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_datapath;

    localparam logic [22:0] K_ENPCA  = 23'd1 << 0;
    localparam logic [22:0] K_ENSPA  = 23'd1 << 1;
    localparam logic [22:0] K_ENMAA  = 23'd1 << 2;
    localparam logic [22:0] K_ENDES  = 23'd1 << 3;
    localparam logic [22:0] K_ENFLD  = 23'd1 << 4;
    localparam logic [22:0] K_MRN    = 23'd1 << 5;
    localparam logic [22:0] K_MWN    = 23'd1 << 6;
    localparam logic [22:0] K_LMAH   = 23'd1 << 7;
    localparam logic [22:0] K_LMAL   = 23'd1 << 8;
    localparam logic [22:0] K_LMD    = 23'd1 << 9;
    localparam logic [22:0] K_LAC    = 23'd1 << 10;
    localparam logic [22:0] K_LAAC   = 23'd1 << 11;
    localparam logic [22:0] K_LCARRY = 23'd1 << 12;
    localparam logic [22:0] K_LZERO  = 23'd1 << 13;
    localparam logic [22:0] K_LINT   = 23'd1 << 14;
    localparam logic [22:0] K_LINTE  = 23'd1 << 15;
    localparam logic [22:0] K_LRESET = 23'd1 << 16;
    localparam logic [22:0] K_INCPC  = 23'd1 << 17;
    localparam logic [22:0] K_INCSP  = 23'd1 << 18;
    localparam logic [22:0] K_DECSP  = 23'd1 << 19;
    localparam logic [22:0] K_OP1    = 23'd1 << 20;
    localparam logic [22:0] K_OP2    = 23'd1 << 21;
    localparam logic [22:0] K_SD0    = 23'd1 << 22;

    // Both memory strobes inactive (high); RD = read active; WR = write active
    localparam logic [22:0] IDLE = K_MRN | K_MWN;
    localparam logic [22:0] RD   = K_MWN;
    localparam logic [22:0] WR   = K_MRN;

    logic        clock = 1'b0;
    logic        reset;
    logic [22:0] ctrl;
    logic        irq;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re, mem_we;
    logic [7:0]  ac, md;
    logic [15:0] aac;
    logic        flag_carry, flag_zero, inte, int_pend;
    logic        ac_zero, md_zero, ac_lt_md, md_lt2, bus_err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clock = ~clock;

    mul_datapath dut (
        .clock      (clock),
        .reset      (reset),
        .ctrl       (ctrl),
        .irq        (irq),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .ac         (ac),
        .md         (md),
        .aac        (aac),
        .flag_carry (flag_carry),
        .flag_zero  (flag_zero),
        .inte       (inte),
        .int_pend   (int_pend),
        .ac_zero    (ac_zero),
        .md_zero    (md_zero),
        .ac_lt_md   (ac_lt_md),
        .md_lt2     (md_lt2),
        .bus_err    (bus_err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one rising edge and land just after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive strobes and read data, then let combinational outputs settle
    task automatic drive(input logic [22:0] c, input logic [7:0] d);
        ctrl      = c;
        mem_rdata = d;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        irq       = 1'b0;
        ctrl      = IDLE;
        mem_rdata = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // Reset state with idle strobes
        drive(IDLE, 8'h00);
        chk8 ("rst_ac",       ac,         8'h00);
        chk8 ("rst_md",       md,         8'h00);
        chk16("rst_aac",      aac,        16'h0000);
        chk1 ("rst_carry",    flag_carry, 1'b0);
        chk1 ("rst_zero",     flag_zero,  1'b0);
        chk1 ("rst_inte",     inte,       1'b0);
        chk1 ("rst_int_pend", int_pend,   1'b0);
        chk1 ("rst_mem_re",   mem_re,     1'b0);
        chk1 ("rst_mem_we",   mem_we,     1'b0);
        chk1 ("rst_bus_err",  bus_err,    1'b0);
        chk16("rst_addr",     mem_addr,   16'h0000);
        chk1 ("rst_ac_zero",  ac_zero,    1'b1);
        chk1 ("rst_md_zero",  md_zero,    1'b1);
        chk1 ("rst_md_lt2",   md_lt2,     1'b1);
        chk1 ("rst_ac_lt_md", ac_lt_md,   1'b0);
        drive(IDLE | K_ENPCA, 8'h00);
        chk16("rst_pc", mem_addr, 16'h0000);
        drive(IDLE | K_ENSPA, 8'h00);
        chk16("rst_sp", mem_addr, 16'hFFFF);

        // Fetch a 16-bit address into MA via the PC
        drive(RD | K_ENPCA | K_LMAH, 8'h12);
        chk16("fetch_hi_addr",  mem_addr,  16'h0000);
        chk1 ("fetch_hi_re",    mem_re,    1'b1);
        chk1 ("fetch_hi_we",    mem_we,    1'b0);
        chk1 ("fetch_hi_err",   bus_err,   1'b0);
        chk8 ("fetch_hi_wdata", mem_wdata, 8'h12);
        tick();
        drive(IDLE | K_INCPC, 8'h00);
        tick();
        drive(RD | K_ENPCA | K_LMAL, 8'h34);
        chk16("fetch_lo_addr", mem_addr, 16'h0001);
        tick();
        drive(IDLE | K_ENMAA, 8'h00);
        chk16("ma_value", mem_addr, 16'h1234);
        drive(IDLE | K_ENPCA, 8'h00);
        chk16("pc_after_inc", mem_addr, 16'h0001);

        // Load AC=C8, MD=64
        drive(RD | K_LAC, 8'hC8);
        tick();
        drive(RD | K_LMD, 8'h64);
        tick();
        drive(IDLE, 8'h00);
        chk8("ld_ac", ac, 8'hC8);
        chk8("ld_md", md, 8'h64);
        chk1("ld_ac_lt_md", ac_lt_md, 1'b0);
        chk1("ld_md_lt2", md_lt2, 1'b0);

        // Add: C8+64 = 12C
        drive(IDLE | K_ENDES | K_OP2 | K_LAC, 8'h00);
        chk8("add_bus", mem_wdata, 8'h2C);
        tick();
        chk8("add_ac", ac, 8'h2C);
        chk1("add_carry", flag_carry, 1'b1);
        chk1("add_zero", flag_zero, 1'b0);
        chk1("add_ac_lt_md", ac_lt_md, 1'b1);

        // Subtract with borrow: 2C-64 = C8, borrow
        drive(IDLE | K_ENDES | K_OP1 | K_OP2 | K_LAC, 8'h00);
        tick();
        chk8("sub1_ac", ac, 8'hC8);
        chk1("sub1_carry", flag_carry, 1'b1);
        // C8-64 = 64, no borrow
        drive(IDLE | K_ENDES | K_OP1 | K_OP2 | K_LAC, 8'h00);
        tick();
        chk8("sub2_ac", ac, 8'h64);
        chk1("sub2_carry", flag_carry, 1'b0);
        // 64-64 = 00
        drive(IDLE | K_ENDES | K_OP1 | K_OP2 | K_LAC, 8'h00);
        tick();
        chk8("sub3_ac", ac, 8'h00);
        chk1("sub3_carry", flag_carry, 1'b0);
        chk1("sub3_zero", flag_zero, 1'b1);

        // Shift right of 01 -> 00, carry out 1
        drive(RD | K_LAC, 8'h01);
        tick();
        drive(IDLE | K_ENDES | K_SD0 | K_OP2 | K_LAC, 8'h00);
        tick();
        chk8("shr_ac", ac, 8'h00);
        chk1("shr_carry", flag_carry, 1'b1);
        chk1("shr_zero", flag_zero, 1'b1);
        chk1("shr_ac_zero", ac_zero, 1'b1);

        // Interrupt enable from dbus bit 2
        drive(RD | K_LINTE, 8'h04);
        tick();
        chk1("inte_set", inte, 1'b1);

        // Stack push of the flag byte at SP=0000
        drive(IDLE | K_INCSP, 8'h00);
        tick();
        drive(WR | K_ENSPA | K_ENFLD, 8'hAA);
        chk16("push_addr", mem_addr, 16'h0000);
        chk1 ("push_we", mem_we, 1'b1);
        chk1 ("push_re", mem_re, 1'b0);
        chk1 ("push_err", bus_err, 1'b0);
        chk8 ("push_wdata", mem_wdata, 8'h07);
        tick();
        drive(IDLE | K_DECSP, 8'h00);
        tick();
        drive(IDLE | K_ENSPA, 8'h00);
        chk16("sp_dec_wrap", mem_addr, 16'hFFFF);
        drive(IDLE | K_INCSP | K_DECSP, 8'h00);
        tick();
        drive(IDLE | K_ENSPA, 8'h00);
        chk16("sp_inc_dec", mem_addr, 16'hFFFF);

        // Pass with LAC forwards MD and clears carry
        drive(IDLE | K_ENDES | K_OP1 | K_LAC, 8'h00);
        chk8("pass_bus", mem_wdata, 8'h64);
        tick();
        chk8("pass_ac", ac, 8'h64);
        chk1("pass_carry", flag_carry, 1'b0);
        chk1("pass_zero", flag_zero, 1'b0);

        // Explicit flag restore; inte untouched
        drive(RD | K_LCARRY | K_LZERO, 8'h03);
        tick();
        chk1("restore_carry", flag_carry, 1'b1);
        chk1("restore_zero", flag_zero, 1'b1);
        chk1("restore_inte", inte, 1'b1);

        // Interrupt latch
        irq = 1'b1;
        drive(IDLE | K_LINT, 8'h00);
        tick();
        irq = 1'b0;
        chk1("int_pend_set", int_pend, 1'b1);

        // Build AAC = 256*FF + F0 = FFF0
        drive(RD | K_LAC, 8'h20);
        tick();
        chk8("acc_ac", ac, 8'h20);
        for (int i = 0; i < 256; i++) begin
            drive(RD | K_LAAC, 8'hFF);
            tick();
        end
        drive(RD | K_LAAC, 8'hF0);
        tick();
        chk16("aac_fff0", aac, 16'hFFF0);
        drive(IDLE | K_ENDES | K_LAAC, 8'h00);
        chk8("acc_bus", mem_wdata, 8'h20);
        tick();
        chk16("aac_wrap", aac, 16'h0010);
        drive(RD | K_LRESET | K_LAAC, 8'h55);
        tick();
        chk16("aac_lreset", aac, 16'h0000);

        // Bus conflicts
        drive(WR | K_ENPCA | K_ENSPA | K_ENDES, 8'h00);
        chk1 ("cf_addr_err", bus_err, 1'b1);
        chk1 ("cf_addr_we", mem_we, 1'b0);
        chk16("cf_addr_pc", mem_addr, 16'h0001);
        drive(23'd0, 8'h00);
        chk1("cf_rw_err", bus_err, 1'b1);
        chk1("cf_rw_we", mem_we, 1'b0);
        drive(WR, 8'h00);
        chk1("cf_nosrc_err", bus_err, 1'b1);
        chk1("cf_nosrc_we", mem_we, 1'b0);

        // Reset overrides a pending load
        drive(RD | K_LAC, 8'h55);
        tick();
        chk8("pre_reset_ac", ac, 8'h55);
        reset = 1'b1;
        drive(RD | K_LAC | K_LAAC | K_INCPC, 8'h77);
        tick();
        reset = 1'b0;
        drive(IDLE, 8'h00);
        chk8 ("mid_rst_ac", ac, 8'h00);
        chk16("mid_rst_aac", aac, 16'h0000);
        chk1 ("mid_rst_carry", flag_carry, 1'b0);
        chk1 ("mid_rst_inte", inte, 1'b0);
        chk1 ("mid_rst_int_pend", int_pend, 1'b0);
        drive(IDLE | K_ENSPA, 8'h00);
        chk16("mid_rst_sp", mem_addr, 16'hFFFF);
        drive(IDLE | K_ENPCA, 8'h00);
        chk16("mid_rst_pc", mem_addr, 16'h0000);
        drive(IDLE | K_ENMAA, 8'h00);
        chk16("mid_rst_ma", mem_addr, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
